link_table_reader: RTL

Read-side counterpart of the link-table dataflow controller. It walks a singly linked list stored in the shared RAM, starting from a supplied head address. Each node's data word is streamed to the outside through a valid/ready handshake. It stops at the null pointer, or flags an error when the node limit is exceeded (loop protection).

---
 rtl/link_table_reader_if.sv | 34 +++
 rtl/link_table_reader.sv | 116 +++++++++++
 2 files changed

// File: rtl/link_table_reader_if.sv
// Bundle of the link-table reader's control, shared-RAM read port and outbound data stream.
// master = the reader itself, slave = the surrounding system (controller, RAM arbiter, consumer).
interface link_table_reader_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  read_start;
    logic [ADDR_WIDTH-1:0] read_head_addr;
    logic                  read_busy;
    logic                  read_done;
    logic                  read_error;
    logic [ADDR_WIDTH-1:0] read_node_count;

    logic                  ram_busy;
    logic                  ram_read_req;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_read_data;

    logic [DATA_WIDTH-1:0] outside_read_data;
    logic                  outside_read_data_valid;
    logic                  outside_read_ready;

    modport master (
        input  read_start, read_head_addr, ram_busy, ram_read_data, outside_read_ready,
        output read_busy, read_done, read_error, read_node_count,
               ram_read_req, ram_addr, outside_read_data, outside_read_data_valid
    );

    modport slave (
        output read_start, read_head_addr, ram_busy, ram_read_data, outside_read_ready,
        input  read_busy, read_done, read_error, read_node_count,
               ram_read_req, ram_addr, outside_read_data, outside_read_data_valid
    );
endinterface

// File: rtl/link_table_reader.sv
// Walks a singly linked list in shared RAM (node = data, next_lo, next_hi) from a head address,
// streaming each node's data word out over valid/ready; stops at the all-ones pointer or the node limit.
module link_table_reader #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_NODES  = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    link_table_reader_if.master bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, OUT, FIN} state_t;

    localparam logic [ADDR_WIDTH-1:0] NULL_PTR = '1;
    localparam logic [ADDR_WIDTH-1:0] MAX_CNT  = ADDR_WIDTH'(MAX_NODES);

    state_t                state;
    logic [ADDR_WIDTH-1:0] node_ptr;
    logic [ADDR_WIDTH-1:0] next_ptr;
    logic [ADDR_WIDTH-1:0] node_count;
    logic [1:0]            phase;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;
    logic                  valid_q;
    logic [ADDR_WIDTH-1:0] count_inc;

    assign count_inc = node_count + ADDR_WIDTH'(1);

    // The RAM strobe must react to ram_busy in the same cycle, so it is decoded from state.
    assign bus.ram_read_req            = (state == ISSUE) && !bus.ram_busy;
    assign bus.ram_addr                = node_ptr + ADDR_WIDTH'(phase);
    assign bus.read_busy               = busy_q;
    assign bus.read_done               = done_q;
    assign bus.read_error              = error_q;
    assign bus.read_node_count         = node_count;
    assign bus.outside_read_data       = data_q;
    assign bus.outside_read_data_valid = valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            node_ptr   <= '0;
            next_ptr   <= '0;
            node_count <= '0;
            phase      <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.read_start) begin
                        node_ptr   <= bus.read_head_addr;
                        node_count <= '0;
                        error_q    <= 1'b0;
                        phase      <= '0;
                        busy_q     <= 1'b1;
                        if (bus.read_head_addr == NULL_PTR) begin
                            state  <= FIN;
                            done_q <= 1'b1;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (!bus.ram_busy) state <= CAPTURE;
                end
                CAPTURE: begin
                    // RAM data arrives the cycle after the strobe; phase selects its destination.
                    case (phase)
                        2'd0:    data_q                           <= bus.ram_read_data;
                        2'd1:    next_ptr[DATA_WIDTH-1:0]          <= bus.ram_read_data;
                        default: next_ptr[ADDR_WIDTH-1:DATA_WIDTH] <= bus.ram_read_data;
                    endcase
                    if (phase == 2'd2) begin
                        state   <= OUT;
                        valid_q <= 1'b1;
                    end else begin
                        phase <= phase + 2'd1;
                        state <= ISSUE;
                    end
                end
                OUT: begin
                    if (bus.outside_read_ready) begin
                        valid_q    <= 1'b0;
                        node_count <= count_inc;
                        if (next_ptr == NULL_PTR) begin
                            state  <= FIN;
                            done_q <= 1'b1;
                        end else if (count_inc == MAX_CNT) begin
                            // Loop protection: the list is longer than allowed (or cyclic).
                            state   <= FIN;
                            done_q  <= 1'b1;
                            error_q <= 1'b1;
                        end else begin
                            node_ptr <= next_ptr;
                            phase    <= '0;
                            state    <= ISSUE;
                        end
                    end
                end
                FIN: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
